// File: rtl/fp_to_int.sv
// Three-stage float-to-integer converter: unpack, align into integer + G/R/S,
// then round, apply sign and saturate, with a global valid/ready stall.
module fp_to_int #(
  parameter int WIDTH  = 16,
  parameter int INT_W  = 16,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int EXP_W  = (WIDTH == 64) ? 11 : (WIDTH == 32) ? 8 : 5;
  localparam int MANT_W = WIDTH - 1 - EXP_W;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int EW     = 16;
  localparam int FW     = MANT_W + INT_W + 3;
  localparam int SH_W   = $clog2(INT_W + 3);

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic signed [EW-1:0] E_DEN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_LO   = EW'(-2);
  localparam logic signed [EW-1:0] E_OVF  = EW'(INT_W + 1);

  localparam logic [INT_W-1:0] MAXV = (SIGNED != 0) ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
  localparam logic [INT_W-1:0] MINV = (SIGNED != 0) ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};
  localparam logic [INT_W+1:0] POS_LIM = {2'b00, MAXV};
  localparam logic [INT_W+1:0] NEG_LIM = {2'b00, MINV};

  logic advance;

  logic                 validS1_q, signS1_q, nanS1_q, infS1_q, zeroS1_q;
  logic                 signS1_d, nanS1_d, infS1_d, zeroS1_d;
  logic signed [EW-1:0] expS1_q, expS1_d;
  logic [MANT_W:0]      sigS1_q, sigS1_d;
  logic [2:0]           rmS1_q, rmS1_d;

  logic                 validS2_q, signS2_q, nanS2_q, infS2_q, zeroS2_q;
  logic [INT_W:0]       magS2_q, magS2_d;
  logic                 gS2_q, rS2_q, sS2_q, ovfS2_q;
  logic                 gS2_d, rS2_d, sS2_d, ovfS2_d;
  logic [2:0]           rmS2_q;

  logic                 outValid_q, outInvalid_q, outInexact_q;
  logic                 outInvalid_d, outInexact_d;
  logic [INT_W-1:0]     outData_q, outData_d;

  logic [EXP_W-1:0]     expField;
  logic [MANT_W-1:0]    manField;
  logic                 tiny;
  logic [SH_W-1:0]      shamt;
  logic [FW-1:0]        frame;
  logic                 inc;
  logic [INT_W+1:0]     rnd;
  logic [INT_W-1:0]     rndLo;

  assign advance   = !outValid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_invalid = outInvalid_q;
  assign out_inexact = outInexact_q;

  assign expField = in_data[WIDTH-2 -: EXP_W];
  assign manField = in_data[MANT_W-1:0];

  always_comb begin
    signS1_d = in_data[WIDTH-1];
    nanS1_d  = (&expField) && (|manField);
    infS1_d  = (&expField) && !(|manField);
    zeroS1_d = !(|expField) && !(|manField);
    expS1_d  = (expField == '0) ? E_DEN : ($signed({{(EW-EXP_W){1'b0}}, expField}) - E_BIAS);
    sigS1_d  = {|expField, manField};
    rmS1_d   = rm;
  end

  // Frame LSB weighs 2^-(MANT_W+2), so shifting by e+2 lands bit 2^0 at MANT_W+2.
  always_comb begin
    tiny    = expS1_q < E_LO;
    ovfS2_d = expS1_q >= E_OVF;
    shamt   = (tiny || ovfS2_d) ? '0 : SH_W'(expS1_q - E_LO);
    frame   = {{(FW-MANT_W-1){1'b0}}, sigS1_q} << shamt;
    magS2_d = frame[FW-1 -: INT_W+1];
    gS2_d   = frame[MANT_W+1];
    rS2_d   = frame[MANT_W];
    sS2_d   = |frame[MANT_W-1:0];
    if (tiny) begin
      magS2_d = '0;
      gS2_d   = 1'b0;
      rS2_d   = 1'b0;
      sS2_d   = |sigS1_q;
    end
  end

  always_comb begin
    case (rmS2_q)
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = !signS2_q && (gS2_q || rS2_q || sS2_q);
      RM_RDN:  inc = signS2_q && (gS2_q || rS2_q || sS2_q);
      RM_RMM:  inc = gS2_q;
      default: inc = gS2_q && (rS2_q || sS2_q || magS2_q[0]);
    endcase
    rnd          = {1'b0, magS2_q} + (INT_W+2)'(inc);
    rndLo        = rnd[INT_W-1:0];
    outData_d    = signS2_q ? -rndLo : rndLo;
    outInvalid_d = 1'b0;
    outInexact_d = gS2_q || rS2_q || sS2_q;
    // Unsigned mode has NEG_LIM = 0, so any nonzero negative lands on MINV = 0.
    if (nanS2_q) begin
      outData_d    = MAXV;
      outInvalid_d = 1'b1;
      outInexact_d = 1'b0;
    end else if (infS2_q || ovfS2_q) begin
      outData_d    = signS2_q ? MINV : MAXV;
      outInvalid_d = 1'b1;
      outInexact_d = 1'b0;
    end else if (zeroS2_q) begin
      outData_d    = '0;
      outInexact_d = 1'b0;
    end else if (!signS2_q && (rnd > POS_LIM)) begin
      outData_d    = MAXV;
      outInvalid_d = 1'b1;
      outInexact_d = 1'b0;
    end else if (signS2_q && (rnd > NEG_LIM)) begin
      outData_d    = MINV;
      outInvalid_d = 1'b1;
      outInexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      validS1_q <= 1'b0; signS1_q <= 1'b0; nanS1_q <= 1'b0; infS1_q <= 1'b0; zeroS1_q <= 1'b0;
      expS1_q <= '0; sigS1_q <= '0; rmS1_q <= '0;
      validS2_q <= 1'b0; signS2_q <= 1'b0; nanS2_q <= 1'b0; infS2_q <= 1'b0; zeroS2_q <= 1'b0;
      magS2_q <= '0; gS2_q <= 1'b0; rS2_q <= 1'b0; sS2_q <= 1'b0; ovfS2_q <= 1'b0; rmS2_q <= '0;
      outValid_q <= 1'b0; outData_q <= '0; outInvalid_q <= 1'b0; outInexact_q <= 1'b0;
    end else if (advance) begin
      validS1_q <= in_valid; signS1_q <= signS1_d; nanS1_q <= nanS1_d; infS1_q <= infS1_d;
      zeroS1_q <= zeroS1_d; expS1_q <= expS1_d; sigS1_q <= sigS1_d; rmS1_q <= rmS1_d;
      validS2_q <= validS1_q; signS2_q <= signS1_q; nanS2_q <= nanS1_q; infS2_q <= infS1_q;
      zeroS2_q <= zeroS1_q; magS2_q <= magS2_d; gS2_q <= gS2_d; rS2_q <= rS2_d;
      sS2_q <= sS2_d; ovfS2_q <= ovfS2_d; rmS2_q <= rmS1_q;
      outValid_q <= validS2_q; outData_q <= outData_d;
      outInvalid_q <= outInvalid_d; outInexact_q <= outInexact_d;
    end
  end

endmodule

// File: doc/fp_to_int.md
Name: fp_to_int

Overview:
- Pipelined converter from an IEEE 754 binary float (fp16/fp32/fp64, selected by WIDTH) to a two's-complement or unsigned integer.
- Sits downstream of the fp arithmetic blocks (fp_add and friends) and hands their results back to the integer datapath.
- Rounding mode encoding is the shared grs_round.vh set.
- Adds valid/ready flow control with a global stall, and reports IEEE invalid and inexact flags.

Parameters:
- WIDTH, 16: float width; 16, 32 or 64 (EXP_W 5/8/11, bias 15/127/1023, MANT_W = WIDTH-1-EXP_W).
- INT_W, 16: output integer width, 8..64.
- SIGNED, 1: 1 = two's-complement result, 0 = unsigned result.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  float operand.
- rm  in  3  rounding mode (`RNE, `RTZ, `RUP, `RDN, `RMM per grs_round.vh); sampled with in_data.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  INT_W  converted integer.
- out_invalid  out  1  NaN, Inf or out-of-range input.
- out_inexact  out  1  result differs from the exact input value (only meaningful when out_invalid=0).

Behaviour:
- Reset (rst=1 at a clock edge):
  - all stage valids, out_valid, out_data, out_invalid and out_inexact go to 0.
  - Beats in flight are discarded; rst mid-stream drops them silently.
- Pipeline: 3 register stages; latency is exactly 3 cycles from the accept edge to out_valid when not stalled.
- Throughput is 1 beat/cycle.
- Global stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, every stage holds its contents.
  - While out_valid=1 and out_ready=0, out_data and the flags are stable.
  - No beat is lost or duplicated; order is preserved.
- S1 unpack/classify:
  - Register sign, NaN, Inf and zero flags.
  - Unbiased exponent e = exp-bias for normals, 1-bias for denormals.
  - Significand {hidden bit, mantissa}, with hidden bit = 0 for exp 0.
  - Register rm.
- S2 align:
  - Form a fixed-point magnitude of INT_W+1 integer bits, plus guard, round and sticky bits.
  - Shift left by e when e ≥ MANT_W; otherwise shift right by MANT_W-e.
  - Every bit shifted below the round bit ORs into sticky.
  - e < -2 gives integer 0, guard 0 and round 0 (when e = -2 the guard bit is the sticky-only case); sticky = significand != 0.
  - Precheck overflow: e ≥ INT_W+1 sets a pre-overflow bit.
- S3 round/sign/saturate:
  - Increment per rm using sign, LSB, G, R and S:
    - RNE: G && (R||S||LSB).
    - RTZ: never.
    - RUP: !sign && (G|R|S).
    - RDN: sign && (G|R|S).
    - RMM: G.
  - inexact = G|R|S.
  - Negate if sign.
  - Range check is done after rounding. Signed range is [-2^(INT_W-1), 2^(INT_W-1)-1]; unsigned range is [0, 2^INT_W-1].
  - Saturation values, each with invalid=1 and inexact=0:
    - NaN → max positive (signed 2^(INT_W-1)-1, unsigned all ones).
    - +Inf or positive overflow → max.
    - -Inf or negative overflow → min (signed -2^(INT_W-1), unsigned 0).
  - Unsigned negative inputs:
    - A rounded magnitude of 0 gives result 0, invalid=0 and inexact as computed.
    - A magnitude ≥ 1 gives result 0 with invalid=1.
  - ±0 gives 0 with no flags; -0 never produces invalid.
  - Exactly -2^(INT_W-1) in signed mode is in range: no invalid.
- Unused rm encodings behave as RNE.

Test Plan:
- Defaults, RNE, in_data 0x3E00 (1.5) → out_data 0x0002, inexact=1, invalid=0, out_valid exactly 3 cycles after accept.
- 0x4100 (2.5) under RNE/RTZ/RUP/RMM → 2/2/3/3. 0xC100 (-2.5) under RNE → 0xFFFE; under RDN → 0xFFFD. All inexact=1.
- Saturation:
  - 0x7BFF (65504) → 0x7FFF, invalid=1.
  - 0x7E00 (NaN) → 0x7FFF, invalid=1.
  - 0xFC00 (-Inf) → 0x8000, invalid=1.
  - 0xF800 (-32768) → 0x8000, invalid=0, inexact=0.
- SIGNED=0:
  - 0xB400 (-0.25, RNE) → 0x0000, inexact=1, invalid=0.
  - 0xBC00 (-1.0) → 0x0000, invalid=1.
  - 0x0001 (min denormal, RUP) → 0x0001, inexact=1.
- Back-to-back stream of 8 beats with out_ready held 0 from cycle 4:
  - in_ready drops the same cycle out_valid is high with out_ready low.
  - out_data is held stable.
  - After out_ready returns to 1, all 8 results emerge in order with no gaps or duplicates.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 the next cycle, none of those beats ever appears, and a new beat issued after reset returns 3 cycles after accept.
